// File: rtl/sys_defs.sv
// Shared types and default sizing for the store-queue drain path.
// Optional perf counters in sq_drain_ctrl are enabled by SQ_DRAIN_PERF_EN.
package sys_defs;

  localparam int N_WAY      = 2;
  localparam int N_WR_PORTS = 1;
  localparam int DEPTH      = 8;
  localparam int XLEN       = 32;
  localparam int POS_W      = 4;

  typedef enum logic [1:0] {
    BYTE = 2'h0,
    HALF = 2'h1,
    WORD = 2'h2
  } MEM_SIZE;

  typedef struct packed {
    logic [XLEN-1:0]  addr;
    logic [XLEN-1:0]  data;
    MEM_SIZE          size;
    logic [POS_W-1:0] pos;
  } SQ_DRAIN_ENTRY;

  typedef enum logic [1:0] {
    RUN   = 2'h0,
    DRAIN = 2'h1,
    DONE  = 2'h2
  } SQ_DRAIN_STATE;

endpackage

// File: rtl/sq_drain_fifo.sv
// Multi-push / multi-pop circular buffer of committed stores.
// Push lanes are contiguous from lane 0; callers never exceed capacity.
module sq_drain_fifo
  import sys_defs::*;
#(
  parameter  int N_PUSH = 2,
  parameter  int N_POP  = 1,
  parameter  int DEPTH  = 8,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1,
  localparam int EW     = $clog2(N_PUSH + 1),
  localparam int DW     = $clog2(N_POP + 1)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [EW-1:0]              push_cnt,
  input  SQ_DRAIN_ENTRY [N_PUSH-1:0] push_ent,
  input  logic [DW-1:0]              pop_cnt,
  output SQ_DRAIN_ENTRY [N_POP-1:0]  head_ent,
  output logic [CNT_W-1:0]           count,
  output logic [CNT_W-1:0]           count_next
);

  SQ_DRAIN_ENTRY    mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;

  assign count_next = count + CNT_W'(push_cnt) - CNT_W'(pop_cnt);

  always_comb begin
    for (int p = 0; p < N_POP; p++) begin
      head_ent[p] = mem[head + PTR_W'(p)];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(pop_cnt);
      tail  <= tail + PTR_W'(push_cnt);
      count <= count_next;
    end
  end

  // Payload storage carries no reset; validity is tracked by count.
  always_ff @(posedge clock) begin
    for (int i = 0; i < N_PUSH; i++) begin
      if (EW'(i) < push_cnt) begin
        mem[tail + PTR_W'(i)] <= push_ent[i];
      end
    end
  end

endmodule

// File: rtl/sq_drain_ctrl.sv
// Commit-side store drain: in-order FIFO to dcache write ports plus drain FSM.
// Define SQ_DRAIN_PERF_EN to build the stall/store perf counters.
module sq_drain_ctrl
  import sys_defs::*;
#(
  parameter  int N_WAY      = sys_defs::N_WAY,
  parameter  int N_WR_PORTS = sys_defs::N_WR_PORTS,
  parameter  int DEPTH      = sys_defs::DEPTH,
  localparam int CNT_W      = $clog2(DEPTH) + 1,
  localparam int EW         = $clog2(N_WAY + 1),
  localparam int DW         = $clog2(N_WR_PORTS + 1)
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic [N_WAY-1:0]                      ret_valid,
  input  logic [N_WAY-1:0][XLEN-1:0]            ret_addr,
  input  logic [N_WAY-1:0][XLEN-1:0]            ret_data,
  input  logic [N_WAY-1:0][1:0]                 ret_size,
  input  logic [N_WAY-1:0][POS_W-1:0]           ret_pos,
  output logic [CNT_W-1:0]                      free_slots,
  output logic [N_WR_PORTS-1:0]                 dc_req_valid,
  output logic [N_WR_PORTS-1:0][XLEN-1:0]       dc_req_addr,
  output logic [N_WR_PORTS-1:0][XLEN-1:0]       dc_req_data,
  output logic [N_WR_PORTS-1:0][1:0]            dc_req_size,
  input  logic [N_WR_PORTS-1:0]                 dc_req_ready,
  output logic [N_WR_PORTS-1:0]                 done_valid,
  output logic [N_WR_PORTS-1:0][POS_W-1:0]      done_pos,
  input  logic                                  drain_req,
  output logic                                  drained,
  output logic                                  err_overflow,
  output logic [31:0]                           perf_stall_cycles,
  output logic [31:0]                           perf_stores
);

  SQ_DRAIN_STATE                    state, state_next;
  SQ_DRAIN_ENTRY [N_WAY-1:0]        push_ent;
  SQ_DRAIN_ENTRY [N_WR_PORTS-1:0]   head_ent;
  logic [CNT_W-1:0]                 count, count_next;
  logic [EW-1:0]                    n_ret, enq;
  logic [DW-1:0]                    deq;
  logic [N_WR_PORTS-1:0]            hs;
  logic                             acc, ovf;
  int                               room;

  sq_drain_fifo #(
    .N_PUSH (N_WAY),
    .N_POP  (N_WR_PORTS),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push_cnt   (enq),
    .push_ent   (push_ent),
    .pop_cnt    (deq),
    .head_ent   (head_ent),
    .count      (count),
    .count_next (count_next)
  );

  always_comb begin
    for (int i = 0; i < N_WAY; i++) begin
      push_ent[i].addr = ret_addr[i];
      push_ent[i].data = ret_data[i];
      push_ent[i].size = MEM_SIZE'(ret_size[i]);
      push_ent[i].pos  = ret_pos[i];
    end
    for (int p = 0; p < N_WR_PORTS; p++) begin
      dc_req_valid[p] = count > CNT_W'(p);
      dc_req_addr[p]  = head_ent[p].addr;
      dc_req_data[p]  = head_ent[p].data;
      dc_req_size[p]  = head_ent[p].size;
    end
  end

  // Prefix acceptance keeps dcache writes in program order.
  always_comb begin
    hs  = '0;
    deq = '0;
    acc = 1'b1;
    for (int p = 0; p < N_WR_PORTS; p++) begin
      acc   = acc & dc_req_valid[p] & dc_req_ready[p];
      hs[p] = acc;
      deq   = deq + DW'(acc);
    end
  end

  always_comb begin
    n_ret = '0;
    for (int i = 0; i < N_WAY; i++) begin
      n_ret = n_ret + EW'(ret_valid[i]);
    end
    room = DEPTH - int'(count) + int'(deq);
    enq  = '0;
    ovf  = 1'b0;
    if (state == RUN) begin
      if (int'(n_ret) > room) begin
        enq = EW'(room);
        ovf = 1'b1;
      end else begin
        enq = n_ret;
      end
    end else begin
      ovf = |ret_valid;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      RUN:     if (drain_req) state_next = DRAIN;
      DRAIN:   if (count_next == '0) state_next = DONE;
      DONE:    if (!drain_req) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  assign drained = (state == DONE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= RUN;
      free_slots   <= CNT_W'(DEPTH);
      done_valid   <= '0;
      done_pos     <= '0;
      err_overflow <= 1'b0;
    end else begin
      state        <= state_next;
      free_slots   <= (state_next == RUN) ? CNT_W'(DEPTH) - count_next : '0;
      done_valid   <= hs;
      err_overflow <= err_overflow | ovf;
      for (int p = 0; p < N_WR_PORTS; p++) begin
        done_pos[p] <= head_ent[p].pos;
      end
    end
  end

`ifdef SQ_DRAIN_PERF_EN
  logic [31:0] stall_q, stores_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_q  <= '0;
      stores_q <= '0;
    end else begin
      if (dc_req_valid[0] && !dc_req_ready[0]) begin
        stall_q <= stall_q + 32'd1;
      end
      stores_q <= stores_q + 32'(deq);
    end
  end

  assign perf_stall_cycles = stall_q;
  assign perf_stores       = stores_q;
`else
  assign perf_stall_cycles = '0;
  assign perf_stores       = '0;
`endif

  a_ret_contig: assert property (
    @(posedge clock) disable iff (reset)
    (ret_valid & (ret_valid + N_WAY'(1))) == '0
  );

endmodule

// File: tb/tb_sq_drain_ctrl.sv
// Random-stimulus bench for sq_drain_ctrl against a queue-based model.
// Perf expectations follow SQ_DRAIN_PERF_EN.
module tb_sq_drain_ctrl;

  localparam int NW = 2;
  localparam int NP = 2;
  localparam int DP = 8;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    logic [3:0]  pos;
  } ent_t;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic [NW-1:0]       ret_valid = '0;
  logic [NW-1:0][31:0] ret_addr = '0;
  logic [NW-1:0][31:0] ret_data = '0;
  logic [NW-1:0][1:0]  ret_size = '0;
  logic [NW-1:0][3:0]  ret_pos = '0;
  logic [3:0]          free_slots;
  logic [NP-1:0]       dc_req_valid;
  logic [NP-1:0][31:0] dc_req_addr;
  logic [NP-1:0][31:0] dc_req_data;
  logic [NP-1:0][1:0]  dc_req_size;
  logic [NP-1:0]       dc_req_ready = '0;
  logic [NP-1:0]       done_valid;
  logic [NP-1:0][3:0]  done_pos;
  logic                drain_req = 1'b0;
  logic                drained;
  logic                err_overflow;
  logic [31:0]         perf_stall_cycles;
  logic [31:0]         perf_stores;

  sq_drain_ctrl #(
    .N_WAY      (NW),
    .N_WR_PORTS (NP),
    .DEPTH      (DP)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .ret_valid         (ret_valid),
    .ret_addr          (ret_addr),
    .ret_data          (ret_data),
    .ret_size          (ret_size),
    .ret_pos           (ret_pos),
    .free_slots        (free_slots),
    .dc_req_valid      (dc_req_valid),
    .dc_req_addr       (dc_req_addr),
    .dc_req_data       (dc_req_data),
    .dc_req_size       (dc_req_size),
    .dc_req_ready      (dc_req_ready),
    .done_valid        (done_valid),
    .done_pos          (done_pos),
    .drain_req         (drain_req),
    .drained           (drained),
    .err_overflow      (err_overflow),
    .perf_stall_cycles (perf_stall_cycles),
    .perf_stores       (perf_stores)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_fail = 0;

  // model state: 0 run, 1 draining, 2 drained
  ent_t        q[$];
  int          md = 0;
  bit          ovf = 0;
  int          exp_free = DP;
  bit [NP-1:0] exp_dv = '0;
  logic [3:0]  exp_dpos [NP];
  logic [31:0] exp_stall = 0;
  logic [31:0] exp_stores = 0;
  int          pos_ctr = 0;

  int ready_mode = 0;
  int force_n = -1;
  bit ovf_ok = 0;
  bit drain_on = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    md = 0;
    ovf = 0;
    exp_free = DP;
    exp_dv = '0;
    exp_stall = 0;
    exp_stores = 0;
  endtask

  task automatic step();
    int   n, sz, deq, room;
    bit   run;
    ent_t e;
    ent_t lane [NW];
    for (int p = 0; p < NP; p++) begin
      chk("req_valid", dc_req_valid[p], q.size() > p);
      if (q.size() > p) begin
        chk("req_addr", dc_req_addr[p], q[p].addr);
        chk("req_data", dc_req_data[p], q[p].data);
        chk("req_size", dc_req_size[p], q[p].size);
      end
      chk("done_valid", done_valid[p], exp_dv[p]);
      if (exp_dv[p]) chk("done_pos", done_pos[p], exp_dpos[p]);
    end
    chk("free_slots", free_slots, exp_free);
    chk("drained", drained, md == 2);
    chk("err_overflow", err_overflow, ovf);
`ifdef SQ_DRAIN_PERF_EN
    chk("perf_stall", perf_stall_cycles, exp_stall);
    chk("perf_stores", perf_stores, exp_stores);
`else
    chk("perf_stall", perf_stall_cycles, 0);
    chk("perf_stores", perf_stores, 0);
`endif
    // drive next inputs
    case (ready_mode)
      1: dc_req_ready = 2'b00;
      2: dc_req_ready = 2'b11;
      3: dc_req_ready = 2'b01;
      default: dc_req_ready = NP'($urandom_range(0, 3));
    endcase
    if (drain_req && md == 2 && (!drain_on || $urandom_range(0, 3) == 0))
      drain_req = 1'b0;
    else if (!drain_req && md == 0 && drain_on && $urandom_range(0, 99) < 5)
      drain_req = 1'b1;
    n = 0;
    if (md == 0) begin
      n = (force_n >= 0) ? force_n : int'($urandom_range(0, 2));
      if (!ovf_ok && n > exp_free) n = exp_free;
    end else if (md == 1 && ovf_ok && $urandom_range(0, 15) == 0) begin
      n = 1;
    end
    for (int i = 0; i < NW; i++) begin
      lane[i].addr = $urandom & 32'hffff_fffc;
      lane[i].data = $urandom;
      lane[i].size = 2'($urandom_range(0, 2));
      lane[i].pos  = 4'((pos_ctr % 15) + 1);
      pos_ctr++;
      ret_valid[i] = (i < n);
      ret_addr[i]  = lane[i].addr;
      ret_data[i]  = lane[i].data;
      ret_size[i]  = lane[i].size;
      ret_pos[i]   = lane[i].pos;
    end
    // model: in-order prefix dequeue, then bounded enqueue
    sz = q.size();
    run = 1;
    deq = 0;
    for (int p = 0; p < NP; p++) begin
      if (run && sz > p && dc_req_ready[p]) deq++;
      else run = 0;
    end
    if (sz > 0 && !dc_req_ready[0]) exp_stall++;
    exp_stores += 32'(deq);
    exp_dv = '0;
    for (int k = 0; k < deq; k++) begin
      e = q.pop_front();
      exp_dv[k] = 1'b1;
      exp_dpos[k] = e.pos;
    end
    if (md == 0) begin
      room = DP - sz + deq;
      for (int i = 0; i < n; i++) begin
        if (i < room) q.push_back(lane[i]);
        else ovf = 1;
      end
    end else if (n > 0) begin
      ovf = 1;
    end
    if (md == 0 && drain_req) md = 1;
    else if (md == 1 && q.size() == 0) md = 2;
    else if (md == 2 && !drain_req) md = 0;
    exp_free = (md == 0) ? DP - q.size() : 0;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ret_valid = '0;
    dc_req_ready = '0;
    drain_req = 1'b0;
    model_reset();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic settle();
    drain_on = 0;
    ready_mode = 0;
    force_n = 0;
    ovf_ok = 0;
    for (int i = 0; i < 300; i++) begin
      if (md == 0 && !drain_req && q.size() == 0) begin
        force_n = -1;
        return;
      end
      step();
    end
    chk("settle_timeout", md, 0);
    force_n = -1;
  endtask

  task automatic run_n(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  logic [31:0] s0;

  initial begin
    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    // basic random traffic
    run_n(200);

    // full FIFO with one in / one out per cycle, across pointer wrap
    settle();
    ready_mode = 1;
    force_n = 2;
    run_n(5);
    ready_mode = 3;
    force_n = 1;
    ovf_ok = 1;
    run_n(12);

    // overflow while stalled, then a long stall
    settle();
    ready_mode = 1;
    force_n = 2;
    ovf_ok = 1;
    run_n(6);
    force_n = 0;
    ovf_ok = 0;
    s0 = perf_stall_cycles;
    run_n(20);
`ifdef SQ_DRAIN_PERF_EN
    chk("stall20", perf_stall_cycles - s0, 20);
`else
    chk("stall20", perf_stall_cycles - s0, 0);
`endif

    // random traffic with drains and injected overflows
    ready_mode = 0;
    force_n = -1;
    ovf_ok = 1;
    drain_on = 1;
    run_n(400);

    // reset with entries pending and a stalled request
    settle();
    ready_mode = 1;
    force_n = 1;
    run_n(5);
    do_reset();
    force_n = 0;
    run_n(2);

    // random traffic with drains, overflow flag must stay clear
    ready_mode = 0;
    force_n = -1;
    ovf_ok = 0;
    drain_on = 1;
    run_n(300);
    settle();
    run_n(2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
